// File: rtl/trojan_mon_pkg.sv
// Shared types and default sizing for the hardware-trojan trigger monitor.
// The log-entry struct describes the layout that log_data_o carries.
package trojan_mon_pkg;

    localparam int DEF_NNETS     = 8;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_TS_W      = 16;
    localparam int DEF_LOG_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_ALARM = 2'd2
    } mon_state_t;

    typedef struct packed {
        logic [DEF_TS_W-1:0]  ts;
        logic [DEF_NNETS-1:0] nets;
    } log_entry_t;

endpackage

// File: rtl/trojan_mon_fifo.sv
// Event-log FIFO: registered storage, push/pop handshake, full/empty flags.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module trojan_mon_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Gated so a freshly reset FIFO never presents stale storage.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/trojan_monitor.sv
// Watches candidate trigger nets for a masked pattern, counts hits, raises a
// sticky alarm at a threshold and logs each hit with a timestamp.
//   state    | meaning
//   ST_IDLE  | monitor disabled, nothing counted or logged
//   ST_ARMED | counting and logging hits, below threshold
//   ST_ALARM | threshold reached; still counting and logging
module trojan_monitor
    import trojan_mon_pkg::*;
#(
    parameter int NNETS     = DEF_NNETS,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int TS_W      = DEF_TS_W,
    parameter int LOG_DEPTH = DEF_LOG_DEPTH
) (
    input  logic                  CK,
    input  logic                  RST,
    input  logic [NNETS-1:0]      nets_i,
    input  logic                  cfg_en_i,
    input  logic [NNETS-1:0]      cfg_pattern_i,
    input  logic [NNETS-1:0]      cfg_mask_i,
    input  logic [CNT_W-1:0]      cfg_thresh_i,
    input  logic                  clear_i,
    output logic                  match_o,
    output logic [CNT_W-1:0]      hit_count_o,
    output logic                  alarm_o,
    output logic                  overflow_o,
    output logic                  log_valid_o,
    input  logic                  log_ready_i,
    output logic [TS_W+NNETS-1:0] log_data_o
);
    mon_state_t       state;
    mon_state_t       state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] thresh_eff;
    logic [TS_W-1:0]  ts;
    logic             hit;
    logic             active;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;

    assign hit        = (|cfg_mask_i) &&
                        ((nets_i & cfg_mask_i) == (cfg_pattern_i & cfg_mask_i));
    assign active     = cfg_en_i && (state != ST_IDLE);
    assign push       = active && hit;
    assign pop        = log_valid_o && log_ready_i;
    assign drop       = push && fifo_full && !pop;
    assign thresh_eff = (cfg_thresh_i == '0) ? CNT_W'(1) : cfg_thresh_i;

    always_comb begin
        count_nxt = count;
        if (clear_i)
            count_nxt = '0;
        else if (push && (count != '1))
            count_nxt = count + CNT_W'(1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cfg_en_i) state_nxt = ST_ARMED;
            ST_ARMED: if (count_nxt >= thresh_eff) state_nxt = ST_ALARM;
            ST_ALARM: if (clear_i) state_nxt = ST_ARMED;
            default:  state_nxt = ST_IDLE;
        endcase
        if (!cfg_en_i) state_nxt = ST_IDLE;
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            count      <= '0;
            match_o    <= 1'b0;
            overflow_o <= 1'b0;
            ts         <= '0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            match_o <= push;
            if (clear_i)
                overflow_o <= 1'b0;
            else if (drop)
                overflow_o <= 1'b1;
            if (cfg_en_i) ts <= ts + TS_W'(1);
        end
    end

    assign hit_count_o = count;
    assign alarm_o     = (state == ST_ALARM);
    assign log_valid_o = !fifo_empty;

    trojan_mon_fifo #(
        .WIDTH (TS_W + NNETS),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk_sys   (CK),
        .rst       (RST),
        .push      (push),
        .push_data ({ts, nets_i}),
        .pop       (pop),
        .pop_data  (log_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
